// File: rtl/id_decode_skid_if.sv
// Handshake/bus bundle for the instruction-decode skid stage.
// slave = the decode stage itself, master = the surrounding pipeline.
interface id_decode_skid_if #(
    parameter int NB_DATA = 32,
    parameter int NB_PC   = 32,
    parameter int NB_REG  = 5
);
    logic               in_valid;
    logic               in_ready;
    logic [NB_DATA-1:0] in_instr;
    logic [NB_PC-1:0]   in_pc;
    logic [1:0]         reg_dst_sel;
    logic               ext_sign;

    logic               out_valid;
    logic               out_ready;
    logic [5:0]         out_op;
    logic [5:0]         out_funct;
    logic [NB_REG-1:0]  out_rs;
    logic [NB_REG-1:0]  out_rt;
    logic [4:0]         out_shamt;
    logic [NB_REG-1:0]  out_dest;
    logic [NB_DATA-1:0] out_imm;
    logic [NB_PC-1:0]   out_jump;
    logic [NB_PC-1:0]   out_pc4;

    modport slave (
        input  in_valid, in_instr, in_pc, reg_dst_sel, ext_sign, out_ready,
        output in_ready, out_valid, out_op, out_funct, out_rs, out_rt,
               out_shamt, out_dest, out_imm, out_jump, out_pc4
    );

    modport master (
        output in_valid, in_instr, in_pc, reg_dst_sel, ext_sign, out_ready,
        input  in_ready, out_valid, out_op, out_funct, out_rs, out_rt,
               out_shamt, out_dest, out_imm, out_jump, out_pc4
    );
endinterface

// File: rtl/id_decode_skid.sv
// MIPS instruction-decode stage with a 2-entry skid buffer and branch flush.
// Optional macro DECODE_STATS_EN adds saturating decode/stall/flush counters.
module id_decode_skid #(
    parameter int NB_DATA  = 32,
    parameter int NB_PC    = 32,
    parameter int NB_REG   = 5,
    parameter int LINK_REG = 31
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    id_decode_skid_if.slave bus
`ifdef DECODE_STATS_EN
    ,
    output logic [31:0] stat_decoded,
    output logic [31:0] stat_stall,
    output logic [31:0] stat_flushed
`endif
);

    typedef struct packed {
        logic [5:0]         op;
        logic [5:0]         funct;
        logic [NB_REG-1:0]  rs;
        logic [NB_REG-1:0]  rt;
        logic [4:0]         shamt;
        logic [NB_REG-1:0]  dest;
        logic [NB_DATA-1:0] imm;
        logic [NB_PC-1:0]   jump;
        logic [NB_PC-1:0]   pc4;
    } rec_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t             r_state;
    rec_t               r_head;
    rec_t               r_skid;
    logic               r_in_ready;
    logic               r_out_valid;

    rec_t               w_dec;
    logic [NB_PC-1:0]   w_pc4;
    logic [NB_DATA-1:0] w_imm;
    logic [NB_REG-1:0]  w_dest;
    logic               w_accept;
    logic               w_emit;

    assign w_accept = bus.in_valid & r_in_ready;
    assign w_emit   = r_out_valid & bus.out_ready;

    assign w_pc4 = bus.in_pc + NB_PC'(4);

    // Upper immediate bits are either copies of bit 15 or zero.
    assign w_imm[15:0] = bus.in_instr[15:0];
    generate
        for (genvar gi = 16; gi < NB_DATA; gi++) begin : g_imm_ext
            assign w_imm[gi] = bus.ext_sign & bus.in_instr[15];
        end
    endgenerate

    always_comb begin
        w_dest = '0;
        case (bus.reg_dst_sel)
            2'b00:   w_dest = bus.in_instr[20:16];
            2'b01:   w_dest = bus.in_instr[15:11];
            2'b10:   w_dest = NB_REG'(LINK_REG);
            default: w_dest = '0;
        endcase
    end

    always_comb begin
        w_dec       = '0;
        w_dec.op    = bus.in_instr[31:26];
        w_dec.funct = bus.in_instr[5:0];
        w_dec.rs    = bus.in_instr[25:21];
        w_dec.rt    = bus.in_instr[20:16];
        w_dec.shamt = bus.in_instr[10:6];
        w_dec.dest  = w_dest;
        w_dec.imm   = w_imm;
        w_dec.jump  = {w_pc4[NB_PC-1:28], bus.in_instr[25:0], 2'b00};
        w_dec.pc4   = w_pc4;
    end

    // Flush drops occupancy only; head/skid data may stay stale.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_head      <= '0;
            r_skid      <= '0;
        end else if (flush) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_head      <= w_dec;
                        r_state     <= ST_ONE;
                        r_out_valid <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_emit) begin
                        r_head <= w_dec;
                    end else if (w_accept) begin
                        r_skid     <= w_dec;
                        r_state    <= ST_TWO;
                        r_in_ready <= 1'b0;
                    end else if (w_emit) begin
                        r_state     <= ST_EMPTY;
                        r_out_valid <= 1'b0;
                    end
                end
                ST_TWO: begin
                    if (w_emit) begin
                        r_head     <= r_skid;
                        r_state    <= ST_ONE;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_op    = r_head.op;
    assign bus.out_funct = r_head.funct;
    assign bus.out_rs    = r_head.rs;
    assign bus.out_rt    = r_head.rt;
    assign bus.out_shamt = r_head.shamt;
    assign bus.out_dest  = r_head.dest;
    assign bus.out_imm   = r_head.imm;
    assign bus.out_jump  = r_head.jump;
    assign bus.out_pc4   = r_head.pc4;

`ifdef DECODE_STATS_EN
    logic [31:0] r_stat_decoded;
    logic [31:0] r_stat_stall;
    logic [31:0] r_stat_flushed;
    logic [1:0]  w_occupancy;
    logic [32:0] w_flushed_sum;

    assign w_occupancy   = (r_state == ST_TWO) ? 2'd2 :
                           (r_state == ST_ONE) ? 2'd1 : 2'd0;
    assign w_flushed_sum = {1'b0, r_stat_flushed} + {31'd0, w_occupancy};

    // A beat offered during a flush is discarded, so it is not counted as decoded.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_decoded <= '0;
            r_stat_stall   <= '0;
            r_stat_flushed <= '0;
        end else begin
            if (w_accept && !flush && (r_stat_decoded != 32'hFFFF_FFFF))
                r_stat_decoded <= r_stat_decoded + 32'd1;
            if (r_out_valid && !bus.out_ready && (r_stat_stall != 32'hFFFF_FFFF))
                r_stat_stall <= r_stat_stall + 32'd1;
            if (flush)
                r_stat_flushed <= w_flushed_sum[32] ? 32'hFFFF_FFFF : w_flushed_sum[31:0];
        end
    end

    assign stat_decoded = r_stat_decoded;
    assign stat_stall   = r_stat_stall;
    assign stat_flushed = r_stat_flushed;
`endif

endmodule

// File: tb/tb_id_decode_skid.sv
// Bench for id_decode_skid: directed decode/handshake cases, then random
// traffic against a queue-based reference of the decode stage.
module tb_id_decode_skid;

    logic clk = 1'b0;
    logic reset;
    logic flush;
    always #5 clk = ~clk;

    id_decode_skid_if #(.NB_DATA(32), .NB_PC(32), .NB_REG(5)) bus ();

`ifdef DECODE_STATS_EN
    logic [31:0] stat_decoded;
    logic [31:0] stat_stall;
    logic [31:0] stat_flushed;
`endif

    id_decode_skid #(.NB_DATA(32), .NB_PC(32), .NB_REG(5), .LINK_REG(31)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
`ifdef DECODE_STATS_EN
        ,
        .stat_decoded (stat_decoded),
        .stat_stall   (stat_stall),
        .stat_flushed (stat_flushed)
`endif
    );

    typedef struct {
        logic [31:0] op, funct, rs, rt, shamt, dest, imm, jump, pc4;
    } exp_t;

    exp_t q[$];
    bit   zero_since_reset;
    int   n_vec  = 0;
    int   n_miss = 0;
    longint m_dec = 0, m_stall = 0, m_flushed = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                        input logic [1:0] sel, input bit sg);
        exp_t r;
        logic [31:0] imm16;
        r.op    = ins / 32'h0400_0000;
        r.funct = ins % 64;
        r.rs    = (ins >> 21) & 31;
        r.rt    = (ins >> 16) & 31;
        r.shamt = (ins >> 6) & 31;
        case (sel)
            2'd0:    r.dest = (ins >> 16) & 31;
            2'd1:    r.dest = (ins >> 11) & 31;
            2'd2:    r.dest = 31;
            default: r.dest = 0;
        endcase
        imm16 = ins & 32'h0000_FFFF;
        r.imm  = (sg && imm16 >= 32768) ? (imm16 | 32'hFFFF_0000) : imm16;
        r.pc4  = pc + 32'd4;
        r.jump = (r.pc4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
        return r;
    endfunction

    task automatic compare();
        chk("in_ready", 64'(bus.in_ready), 64'(q.size() < 2));
        chk("out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
        if (q.size() > 0) begin
            chk("op", 64'(bus.out_op), 64'(q[0].op));
            chk("funct", 64'(bus.out_funct), 64'(q[0].funct));
            chk("rs", 64'(bus.out_rs), 64'(q[0].rs));
            chk("rt", 64'(bus.out_rt), 64'(q[0].rt));
            chk("shamt", 64'(bus.out_shamt), 64'(q[0].shamt));
            chk("dest", 64'(bus.out_dest), 64'(q[0].dest));
            chk("imm", 64'(bus.out_imm), 64'(q[0].imm));
            chk("jump", 64'(bus.out_jump), 64'(q[0].jump));
            chk("pc4", 64'(bus.out_pc4), 64'(q[0].pc4));
        end else if (zero_since_reset) begin
            chk("rst_dest", 64'(bus.out_dest), 64'd0);
            chk("rst_imm", 64'(bus.out_imm), 64'd0);
            chk("rst_jump", 64'(bus.out_jump), 64'd0);
            chk("rst_pc4", 64'(bus.out_pc4), 64'd0);
        end
`ifdef DECODE_STATS_EN
        chk("stat_decoded", 64'(stat_decoded), 64'(m_dec));
        chk("stat_stall", 64'(stat_stall), 64'(m_stall));
        chk("stat_flushed", 64'(stat_flushed), 64'(m_flushed));
`endif
    endtask

    // One clock: drive inputs, advance the reference, then check after the edge.
    task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic [1:0] sel, input bit sg, input bit ordy,
                        input bit fl, input bit rs);
        bit acc, emt;
        int occ;
        bus.in_valid    = v;
        bus.in_instr    = ins;
        bus.in_pc       = pc;
        bus.reg_dst_sel = sel;
        bus.ext_sign    = sg;
        bus.out_ready   = ordy;
        flush           = fl;
        reset           = rs;
        occ = q.size();
        acc = v && (occ < 2);
        emt = (occ > 0) && ordy;
        if (rs) begin
            q.delete();
            zero_since_reset = 1'b1;
            m_dec = 0; m_stall = 0; m_flushed = 0;
        end else begin
            if (occ > 0 && !ordy) m_stall++;
            if (fl) begin
                m_flushed += occ;
                q.delete();
            end else begin
                if (acc) m_dec++;
                if (emt) void'(q.pop_front());
                if (acc) begin
                    q.push_back(ref_decode(ins, pc, sel, sg));
                    zero_since_reset = 1'b0;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        compare();
        $display("t=%0t v=%0b instr=%h pc=%h sel=%0d sg=%0b ordy=%0b fl=%0b rst=%0b -> ovalid=%0b irdy=%0b occ=%0d",
                 $time, v, ins, pc, sel, sg, ordy, fl, rs, bus.out_valid, bus.in_ready, q.size());
    endtask

    initial begin
        zero_since_reset = 1'b0;
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
        chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset_op", 64'(bus.out_op), 64'd0);

        // add $8,$9,$10
        step(1, 32'h012A4020, 32'h0000_0100, 2'b01, 0, 1, 0, 0);
        chk("add_valid", 64'(bus.out_valid), 64'd1);
        chk("add_op", 64'(bus.out_op), 64'd0);
        chk("add_rs", 64'(bus.out_rs), 64'd9);
        chk("add_rt", 64'(bus.out_rt), 64'd10);
        chk("add_dest", 64'(bus.out_dest), 64'd8);
        chk("add_funct", 64'(bus.out_funct), 64'h20);

        // addi $8,$9,-1 with both extension modes
        step(1, 32'h2128FFFF, 32'h0000_0104, 2'b00, 1, 1, 0, 0);
        chk("imm_sext", 64'(bus.out_imm), 64'hFFFF_FFFF);
        chk("imm_dest_rt", 64'(bus.out_dest), 64'd8);
        step(1, 32'h2128FFFF, 32'h0000_0108, 2'b00, 0, 1, 0, 0);
        chk("imm_zext", 64'(bus.out_imm), 64'h0000_FFFF);

        // jal
        step(1, 32'h0C000040, 32'h1000_0008, 2'b10, 0, 1, 0, 0);
        chk("jal_dest", 64'(bus.out_dest), 64'd31);
        chk("jal_pc4", 64'(bus.out_pc4), 64'h1000_000C);
        chk("jal_jump", 64'(bus.out_jump), 64'h1000_0100);

        // pc wrap and dest none
        step(1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 2'b11, 1, 1, 0, 0);
        chk("wrap_pc4", 64'(bus.out_pc4), 64'd0);
        chk("none_dest", 64'(bus.out_dest), 64'd0);
        step(0, 0, 0, 0, 0, 1, 0, 0);

        // backpressure A, B, C
        step(1, 32'h0000_0AAA, 32'h0000_1000, 2'b01, 0, 0, 0, 0);
        step(1, 32'h0000_0BBB, 32'h0000_2000, 2'b01, 0, 0, 0, 0);
        chk("bp_full", 64'(bus.in_ready), 64'd0);
        chk("bp_head_a", 64'(bus.out_pc4), 64'h0000_1004);
        step(1, 32'h0000_0CCC, 32'h0000_3000, 2'b01, 0, 0, 0, 0);
        chk("bp_hold_a", 64'(bus.out_pc4), 64'h0000_1004);
        step(1, 32'h0000_0CCC, 32'h0000_3000, 2'b01, 0, 1, 0, 0);
        chk("bp_head_b", 64'(bus.out_pc4), 64'h0000_2004);
        step(1, 32'h0000_0CCC, 32'h0000_3000, 2'b01, 0, 1, 0, 0);
        chk("bp_head_c", 64'(bus.out_pc4), 64'h0000_3004);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        chk("bp_drained", 64'(bus.out_valid), 64'd0);

        // flush with state TWO and a beat offered
        step(1, 32'h0000_0111, 32'h0000_4000, 2'b00, 0, 0, 0, 0);
        step(1, 32'h0000_0222, 32'h0000_5000, 2'b00, 0, 0, 0, 0);
        step(1, 32'h0000_0333, 32'h0000_6000, 2'b00, 0, 0, 1, 0);
        chk("flush_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_ready", 64'(bus.in_ready), 64'd1);
`ifdef DECODE_STATS_EN
        chk("flush_stat", 64'(stat_flushed), 64'd2);
`endif
        step(0, 0, 0, 0, 0, 1, 0, 0);
        chk("flush_dropped", 64'(bus.out_valid), 64'd0);

        // reset mid-operation
        step(1, 32'h2128FFFF, 32'h0000_7000, 2'b01, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        chk("mrst_valid", 64'(bus.out_valid), 64'd0);
        chk("mrst_ready", 64'(bus.in_ready), 64'd1);
        chk("mrst_dest", 64'(bus.out_dest), 64'd0);
        chk("mrst_imm", 64'(bus.out_imm), 64'd0);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom, $urandom,
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 49) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/id_decode_skid.md
Name: id_decode_skid

Overview:
- Registered, parametrised instruction-decode stage for the MIPS pipeline; sits between the IF/ID boundary and the register file / control unit.
- Splits a fetched instruction into opcode, funct, rs, rt, shamt, extended immediate and jump target.
- Selects the destination register from a multi-mode selector.
- Buffers results in a 2-entry skid buffer with valid/ready handshake, plus a pipeline flush for branches and jumps.

Parameters:
- NB_DATA, 32, instruction and datapath width; instruction field positions assume 32.
- NB_PC, 32, program counter width.
- NB_REG, 5, register index width.
- LINK_REG, 31, destination index used for link (jal) writes.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous pipeline flush, active-high.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  stage can accept a beat; registered.
- in_instr  input  NB_DATA  fetched instruction.
- in_pc  input  NB_PC  address of in_instr.
- reg_dst_sel  input  2  destination mode: 00 rt, 01 rd, 10 LINK_REG, 11 none (index 0).
- ext_sign  input  1  1 = sign-extend immediate, 0 = zero-extend.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts beat.
- out_op  output  6  instr[31:26].
- out_funct  output  6  instr[5:0].
- out_rs  output  NB_REG  instr[25:21].
- out_rt  output  NB_REG  instr[20:16].
- out_shamt  output  5  instr[10:6].
- out_dest  output  NB_REG  selected destination register.
- out_imm  output  NB_DATA  extended instr[15:0].
- out_jump  output  NB_PC  {pc_plus4[NB_PC-1:28], instr[25:0], 2'b00}.
- out_pc4  output  NB_PC  in_pc + 4, modulo 2^NB_PC.

Behaviour:
- Reset values:
  - Occupancy becomes EMPTY.
  - in_ready=1, out_valid=0.
  - All data outputs are 0.
- Decode is combinational on the input beat. The decoded record (all out_* fields) is captured into the buffer on accept. reg_dst_sel and ext_sign are sampled with the beat.
- Accept and emit conditions:
  - Accept = in_valid & in_ready.
  - Emit = out_valid & out_ready.
- Occupancy FSM:
  - EMPTY: accept -> ONE.
  - ONE:
    - accept & emit -> ONE; the new beat becomes the head.
    - accept & !emit -> TWO; the beat goes to the skid slot.
    - emit & !accept -> EMPTY.
  - TWO: emit -> ONE; the skid slot moves to the head. in_ready=0, so no accept is possible.
- Outputs derived from occupancy:
  - in_ready = (state != TWO), registered.
  - out_valid = (state != EMPTY).
  - Outputs always present the head entry.
- Latency and throughput:
  - Latency is 1 cycle from accept to out_valid.
  - Full throughput of 1 beat/cycle when out_ready=1.
- Output stability: while out_valid & !out_ready, all out_* fields are held stable.
- Destination selection:
  - reg_dst_sel=11 forces out_dest=0; writes to $0 are benign.
  - reg_dst_sel=10 forces out_dest=LINK_REG regardless of instruction bits.
- Immediate extension:
  - Sign extend replicates instr[15] into bits NB_DATA-1:16.
  - Zero extend fills those bits with 0.
- PC arithmetic: out_pc4 wraps, e.g. in_pc=0xFFFFFFFC gives 0x00000000.
- Flush:
  - Next state is EMPTY, out_valid=0 and in_ready=1 on the next cycle.
  - Any beat offered in the flush cycle is discarded.
  - Flush has priority over accept and emit.
  - Data registers may keep stale values.
- Reset has priority over flush.

Optional Feature:
- Macro DECODE_STATS_EN.
- When defined, adds three outputs:
  - stat_decoded: 32 bits, counts accepts.
  - stat_stall: 32 bits, counts cycles with out_valid & !out_ready.
  - stat_flushed: 32 bits, adds the number of entries discarded by each flush (0, 1 or 2).
- All three counters:
  - Clear on reset.
  - Saturate at 0xFFFFFFFF.
  - Are unaffected by flush except stat_flushed.
- When not defined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Pass-through decode: reset, then in_instr=0x012A4020 (add $8,$9,$10), reg_dst_sel=01, out_ready=1.
  - Next cycle: out_valid=1, out_op=0, out_rs=9, out_rt=10, out_dest=8, out_funct=0x20.
- Immediate extension: in_instr=0x2128FFFF (addi $8,$9,-1).
  - ext_sign=1 gives out_imm=0xFFFFFFFF.
  - ext_sign=0 gives out_imm=0x0000FFFF.
  - reg_dst_sel=00 gives out_dest=8.
- Jal link: in_pc=0x10000008, in_instr=0x0C000040, reg_dst_sel=10.
  - out_dest=31, out_pc4=0x1000000C, out_jump=0x10000100.
- Backpressure: stream beats A,B,C with out_ready=0.
  - A appears on the output; B is held in the skid slot; in_ready=0 on the cycle after B is accepted; C is held upstream.
  - Raise out_ready: A, B, C emerge in order with no loss or duplication and fields stable while stalled.
- Flush mid-fill: with state TWO, assert flush together with in_valid=1.
  - Next cycle: out_valid=0, in_ready=1, offered beat not emitted.
  - With DECODE_STATS_EN: stat_flushed=2.
- Reset mid-operation: with state ONE and out_ready=0, assert reset.
  - Next cycle: out_valid=0, in_ready=1, out_dest=0, out_imm=0.
